imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that fills the instruction memory read by the fetch unit, acting as the write side of that memory port. It receives a framed byte stream over a valid/ready handshake, assembles 9-bit instructions, writes them at sequential addresses and checks length and checksum. On success it releases the single-cycle CPU from hold and pulses its start; on failure it keeps the CPU held.

## Interface
- INSTR_W, 9, instruction width written to instruction memory
- ADDR_W, 16, instruction memory address width (matches pc width)
- DEPTH, 256, maximum number of words accepted in one frame
- clk  input  1  system clock, rising-edge
- init  input  1  reset; synchronous, active-low (init==0 at a rising clk edge resets)
- rx_data  input  8  incoming frame byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader can accept a byte
- imem_we  output  1  instruction memory write strobe (one cycle per word)
- imem_addr  output  ADDR_W  write address
- imem_wdata  output  INSTR_W  write data
- cpu_hold  output  1  holds the CPU in init while high
- cpu_start  output  1  one-cycle start pulse to the fetch unit
- done  output  1  sticky: frame loaded and verified
- error  output  1  sticky: frame rejected
- word_count  output  16  words written so far in the current frame

## Operation
- Byte transfer: a byte is accepted on any rising edge with rx_valid && rx_ready. rx_data is ignored otherwise.
- Frame format:
  - SYNC 0xA5.
  - LEN_HI, LEN_LO: N words, big-endian.
  - N word pairs (HI, LO), where instr = {HI[0], LO}. HI[7:1] must be 0.
  - CKSUM: XOR of every byte after SYNC and before CKSUM.
- FSM states: IDLE, LEN_HI, LEN_LO, W_HI, W_LO, CKSUM, DONE, ERROR.
  - IDLE: a byte other than 0xA5 is discarded and the state stays IDLE. 0xA5 clears the checksum accumulator and word_count, then goes to LEN_HI.
  - LEN_HI -> LEN_LO.
  - LEN_LO: if N > DEPTH -> ERROR. If N == 0 -> CKSUM. Otherwise -> W_HI.
  - W_HI: if HI[7:1] != 0 -> ERROR. Otherwise -> W_LO.
  - W_LO: issues the write. Goes to W_HI, or to CKSUM if this was word N.
  - CKSUM: if the byte equals the accumulator -> DONE, otherwise -> ERROR.
  - DONE and ERROR are terminal until reset.
- rx_ready: 1 in IDLE through CKSUM; 0 in DONE, ERROR and during reset.
- Writes are sequential from address 0. Memory contents are never cleared by the loader.
- Checksum is 8-bit XOR; the length and word bytes all fold into it.
- Reset mid-frame: returns to IDLE with all outputs at reset values. Partial writes already made remain in memory.

## Timing
- Reset values: rx_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 1, cpu_start 0, done 0, error 0, word_count 0. rx_ready rises the first cycle after init returns high.
- Write latency: a LO byte accepted at edge k produces imem_we=1 with addr/wdata valid during cycle k+1. word_count increments at the same edge (k+1).
- imem_addr = word index (0..N-1); it holds its last value when imem_we=0.
- A CKSUM byte accepted at edge k gives, in cycle k+1:
  - DONE: cpu_hold=0, done=1, cpu_start=1 for exactly that cycle.
  - ERROR: error=1, cpu_hold stays 1.
- ERROR on a length or reserved-bit fault is visible the cycle after the offending byte is accepted.
- Back-to-back bytes (rx_valid held high) are accepted every cycle with no bubbles.

## Structure
- Shared package loader_pkg: SYNC_BYTE=8'hA5, state enumeration, INSTR_W default.
- Single module; no sub-module. Checksum accumulator and word assembly are inline registers.

## Test plan
- Nominal frame: A5 00 02 01 23 00 FF DF.
  - Writes [0]=9'h123, [1]=9'h0FF, each as a single-cycle imem_we.
  - Then done=1, cpu_start pulses 1 cycle, cpu_hold=0, rx_ready=0.
- Empty frame: A5 00 00 00 -> no writes, done=1, cpu_start pulse, word_count=0.
- Leading garbage 3C 11 followed by the nominal frame -> garbage discarded; same result as the nominal case.
- Oversize frame: A5 01 01 (N=257 with DEPTH=256) -> error=1 the cycle after LEN_LO, no writes, rx_ready=0, cpu_hold=1.
- Faulty frames:
  - Nominal frame with CKSUM DE: both writes occur, then error=1 and cpu_start never asserts.
  - HI byte 0x03: error=1 and no write for that word.
- Reset after A5 00 02 01 23 -> all outputs at reset values. Resending the nominal frame then loads correctly with done=1, at full rate with rx_valid held high.

Source files
------------

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Package   : loader_pkg
// Purpose   : Shared constants and state encoding for the instruction-memory
//             boot loader.
// Revision  : 1.0 - initial release
// ============================================================================
package loader_pkg;

  // Frame start marker; every other byte seen while idle is discarded.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Instruction width of the single-cycle CPU (HI[0] concatenated with LO).
  localparam int unsigned INSTR_W_DEFAULT = 9;

  // Loader frame-parsing states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_W_HI   = 3'd3,
    S_W_LO   = 3'd4,
    S_CKSUM  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_e;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module    : imem_loader
// Purpose   : Boot-time loader. Parses a framed byte stream (SYNC, LEN, word
//             pairs, XOR checksum), writes instructions to sequential
//             instruction-memory addresses and releases the CPU on success.
// Revision  : 1.0 - initial release
// ============================================================================
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEFAULT,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 256
) (
  input  logic               clk,
  input  logic               init,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               cpu_start,
  output logic               done,
  output logic               error,
  output logic [15:0]        word_count
);

  state_e               state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic [7:0]           cksum_q, cksum_d;
  logic                 hi_bit_q, hi_bit_d;
  logic [15:0]          count_q, count_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0]   wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic                 start_q, start_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 ready_q, ready_d;

  logic                 accept;
  logic [15:0]          len_full;
  logic [15:0]          count_inc;

  // rx_ready is registered, so it is low through reset and rises one cycle
  // after init is released.
  assign accept    = rx_valid && ready_q;
  assign len_full  = {len_q[15:8], rx_data};
  assign count_inc = count_q + 16'd1;

  // Frame parser: next state, checksum folding, word assembly and write issue.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cksum_d  = cksum_q;
    hi_bit_d = hi_bit_q;
    count_d  = count_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;

    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            cksum_d = 8'h00;
            count_d = 16'd0;
            state_d = S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          len_d   = {rx_data, len_q[7:0]};
          cksum_d = cksum_q ^ rx_data;
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d   = len_full;
          cksum_d = cksum_q ^ rx_data;
          if (32'(len_full) > DEPTH) begin
            state_d = S_ERROR;
          end else if (len_full == 16'd0) begin
            state_d = S_CKSUM;
          end else begin
            state_d = S_W_HI;
          end
        end
        S_W_HI: begin
          cksum_d  = cksum_q ^ rx_data;
          hi_bit_d = rx_data[0];
          // Only bit 0 of the HI byte carries data; the rest is reserved.
          state_d  = (rx_data[7:1] != 7'd0) ? S_ERROR : S_W_LO;
        end
        S_W_LO: begin
          cksum_d = cksum_q ^ rx_data;
          we_d    = 1'b1;
          addr_d  = ADDR_W'(count_q);
          wdata_d = INSTR_W'({hi_bit_q, rx_data});
          count_d = count_inc;
          state_d = (count_inc == len_q) ? S_CKSUM : S_W_HI;
        end
        S_CKSUM: begin
          state_d = (rx_data == cksum_q) ? S_DONE : S_ERROR;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // Status flags follow the state they lead into, so they appear the
    // cycle after the deciding byte.
    done_d  = done_q  || (state_d == S_DONE);
    error_d = error_q || (state_d == S_ERROR);
    start_d = (state_q == S_CKSUM) && (state_d == S_DONE);
    ready_d = (state_d != S_DONE) && (state_d != S_ERROR);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!init) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; memory contents are not touched by reset.
  always_ff @(posedge clk) begin
    if (!init) begin
      len_q    <= 16'd0;
      cksum_q  <= 8'h00;
      hi_bit_q <= 1'b0;
      count_q  <= 16'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      len_q    <= len_d;
      cksum_q  <= cksum_d;
      hi_bit_q <= hi_bit_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      start_q  <= start_d;
      done_q   <= done_d;
      error_q  <= error_d;
      ready_q  <= ready_d;
    end
  end

  assign rx_ready   = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = ~done_q;
  assign cpu_start  = start_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = count_q;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module    : tb_imem_loader
// Purpose   : Directed frames into imem_loader; expected writes go into a
//             queue that a negedge monitor pops whenever imem_we is seen.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        init;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [8:0]  imem_wdata;
  logic        cpu_hold;
  logic        cpu_start;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  imem_loader #(
    .INSTR_W (9),
    .ADDR_W  (16),
    .DEPTH   (256)
  ) dut (
    .clk        (clk),
    .init       (init),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .cpu_start  (cpu_start),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [8:0]  data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  total  = 0;
  int  bad    = 0;
  int  cyc    = 0;
  int  starts = 0;

  // Cycle counter: value after edge K identifies the cycle following edge K.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (init === 1'b1 && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr",  32'(imem_addr),  32'(e.addr));
        check("wr_data",  32'(imem_wdata), 32'(e.data));
        check("wr_cycle", cyc,             e.cyc);
      end
    end
    if (init === 1'b1 && cpu_start === 1'b1) starts++;
  end

  task automatic push_wr(input logic [15:0] a, input logic [8:0] d);
    exp_q.push_back('{addr: a, data: d, cyc: cyc});
  endtask

  // Present one byte and hold it until an edge with rx_ready high takes it.
  task automatic send(input logic [7:0] b);
    bit ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rx_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte %0h not accepted, expected acceptance", b);
    end
  endtask

  task automatic send_nominal(input logic [7:0] ck);
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h01); send(8'h23); push_wr(16'd0, 9'h123);
    send(8'h00); send(8'hFF); push_wr(16'd1, 9'h0FF);
    send(ck);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    init     = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_rx_ready",   32'(rx_ready),   32'd0);
    check("rst_imem_we",    32'(imem_we),    32'd0);
    check("rst_imem_addr",  32'(imem_addr),  32'd0);
    check("rst_imem_wdata", 32'(imem_wdata), 32'd0);
    check("rst_cpu_hold",   32'(cpu_hold),   32'd1);
    check("rst_cpu_start",  32'(cpu_start),  32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_error",      32'(error),      32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    init = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_rise", 32'(rx_ready), 32'd1);
  endtask

  // Status right after a verified checksum, then the start pulse must drop.
  task automatic expect_done(input logic [15:0] words, input int starts0);
    check("done",        32'(done),       32'd1);
    check("start_pulse", 32'(cpu_start),  32'd1);
    check("hold_low",    32'(cpu_hold),   32'd0);
    check("ready_low",   32'(rx_ready),   32'd0);
    check("error_low",   32'(error),      32'd0);
    check("words",       32'(word_count), 32'(words));
    @(posedge clk); #1;
    check("start_drop",  32'(cpu_start),  32'd0);
    check("done_sticky", 32'(done),       32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("pending_wr",  32'(exp_q.size()), 32'd0);
    check("start_count", starts - starts0,  1);
  endtask

  task automatic expect_error(input logic [15:0] words, input int starts0);
    check("error",       32'(error),      32'd1);
    check("done_low",    32'(done),       32'd0);
    check("hold_high",   32'(cpu_hold),   32'd1);
    check("ready_low",   32'(rx_ready),   32'd0);
    check("words",       32'(word_count), 32'(words));
    repeat (3) @(posedge clk);
    #1;
    check("error_sticky", 32'(error),         32'd1);
    check("pending_wr",   32'(exp_q.size()),  32'd0);
    check("start_count",  starts - starts0,   0);
  endtask

  initial begin
    int s0;
    int c0;
    init     = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Nominal frame.
    do_reset();
    s0 = starts;
    send_nominal(8'hDF);
    expect_done(16'd2, s0);

    // Leading garbage then nominal frame.
    do_reset();
    s0 = starts;
    send(8'h3C); send(8'h11);
    send_nominal(8'hDF);
    expect_done(16'd2, s0);

    // Empty frame.
    do_reset();
    s0 = starts;
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    rx_valid = 1'b0;
    expect_done(16'd0, s0);

    // Oversize frame N=257.
    do_reset();
    s0 = starts;
    send(8'hA5); send(8'h01); send(8'h01);
    rx_valid = 1'b0;
    expect_error(16'd0, s0);

    // Bad checksum: writes still happen, no start.
    do_reset();
    s0 = starts;
    send_nominal(8'hDE);
    expect_error(16'd2, s0);

    // Reserved HI bits set on the first word.
    do_reset();
    s0 = starts;
    send(8'hA5); send(8'h00); send(8'h02); send(8'h03);
    rx_valid = 1'b0;
    expect_error(16'd0, s0);

    // Reset mid-frame, then a full-rate reload.
    do_reset();
    send(8'hA5); send(8'h00); send(8'h02); send(8'h01); send(8'h23);
    push_wr(16'd0, 9'h123);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_words", 32'(word_count), 32'd1);
    do_reset();
    s0 = starts;
    c0 = cyc;
    send_nominal(8'hDF);
    check("full_rate_cycles", cyc - c0, 8);
    expect_done(16'd2, s0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_imem_loader
`default_nettype wire
